sccb_master: RTL and testbench

Parametrised SCCB/I2C-style master for camera sensor register access, driven by the sensor configuration sequencer.
- Runs 3-phase writes and, when compiled in, 2-phase-write + 2-phase-read register reads.
- Supports 8- or 16-bit register addresses, a parametrised bit rate and a split-direction data pin for an external tri-state buffer.
- Uses a single clock domain and a valid/ready request port with a one-cycle completion pulse.

---
 rtl/sccb_master.sv | 249 ++++++++++++++++++++++++
 tb/tb_sccb_master.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_master.sv
// rtl/sccb_master.sv - SCCB/I2C-style register-access master with quarter-tick bus sequencing.
// Define SCCB_READ_EN to build in register reads; otherwise rd=1 requests complete with err.
module sccb_master #(
    parameter int CLK_DIV   = 125,
    parameter int REG_BYTES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    output logic                   ready,
    input  logic                   rd,
    input  logic [7:0]             id,
    input  logic [8*REG_BYTES-1:0] regi,
    input  logic [7:0]             wdata,
    output logic                   done,
    output logic [7:0]             rdata,
    output logic                   err,
    output logic                   busy,
    output logic                   sioc,
    output logic                   siod_o,
    output logic                   siod_oe,
    input  logic                   siod_i
);

    localparam int          FW      = 8 * (REG_BYTES + 2);
    localparam logic [11:0] DIV_M1  = 12'(CLK_DIV - 1);
    localparam logic [1:0]  LAST_WR = 2'(REG_BYTES + 1);
    localparam logic [1:0]  LAST_RD = 2'(REG_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_TX,
        S_RX,
        S_STOP,
        S_GAP,
        S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [11:0]     cnt_q, cnt_d;
    logic [1:0]      qtr_q, qtr_d;
    logic [3:0]      bit_q, bit_d;
    logic [1:0]      byte_q, byte_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [6:0]      id_q, id_d;
    logic            rd_q, rd_d;
    logic            phase_q, phase_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            sioc_q, sioc_d;
    logic            siod_o_q, siod_o_d;
    logic            siod_oe_q, siod_oe_d;
    logic            tick;
    logic            last_byte;
    logic            unused_id0;

    assign unused_id0 = id[0];
    assign tick       = (cnt_q == DIV_M1);
    // Phase 2 of a read carries only the id|1 byte.
    assign last_byte  = phase_q ? 1'b1 : (byte_q == (rd_q ? LAST_RD : LAST_WR));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        frame_d = frame_q;
        id_d    = id_q;
        rd_d    = rd_q;
        phase_d = phase_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;

        if (state_q == S_IDLE) begin
            if (req) begin
                id_d    = id[7:1];
                rd_d    = rd;
                phase_d = 1'b0;
                cnt_d   = '0;
                qtr_d   = '0;
                bit_d   = '0;
                byte_d  = '0;
                frame_d = {id[7:1], 1'b0, regi, wdata};
`ifdef SCCB_READ_EN
                state_d = S_START;
`else
                state_d = rd ? S_ERR : S_START;
`endif
            end
        end else if (state_q == S_ERR) begin
            cnt_d = cnt_q + 12'd1;
            if (cnt_q == 12'd1) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                err_d   = 1'b1;
            end
        end else begin
            cnt_d = tick ? '0 : cnt_q + 12'd1;
            if (tick) begin
                qtr_d = qtr_q + 2'd1;
                case (state_q)
                    S_START: begin
                        if (qtr_q == 2'd3) begin
                            state_d = S_TX;
                            bit_d   = '0;
                            byte_d  = '0;
                        end
                    end
                    S_TX: begin
                        if (qtr_q == 2'd3) begin
                            if (bit_q == 4'd8) begin
                                bit_d = '0;
                                if (last_byte) begin
                                    state_d = phase_q ? S_RX : S_STOP;
                                end else begin
                                    byte_d = byte_q + 2'd1;
                                end
                            end else begin
                                bit_d   = bit_q + 4'd1;
                                frame_d = frame_q << 1;
                            end
                        end
                    end
                    S_RX: begin
                        if (qtr_q == 2'd2 && bit_q != 4'd8) begin
                            rdata_d = {rdata_q[6:0], siod_i};
                        end
                        if (qtr_q == 2'd3) begin
                            if (bit_q == 4'd8) begin
                                state_d = S_STOP;
                                bit_d   = '0;
                            end else begin
                                bit_d = bit_q + 4'd1;
                            end
                        end
                    end
                    S_STOP: begin
                        if (qtr_q == 2'd3) begin
                            state_d = S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (qtr_q == 2'd3) begin
`ifdef SCCB_READ_EN
                            if (rd_q && !phase_q) begin
                                state_d = S_START;
                                phase_d = 1'b1;
                                frame_d = {id_q, 1'b1, {(FW - 8){1'b0}}};
                            end else begin
                                state_d = S_IDLE;
                                done_d  = 1'b1;
                            end
`else
                            state_d = S_IDLE;
                            done_d  = 1'b1;
`endif
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    // Bus pins are decoded from the next position so they register on the same tick edge.
    always_comb begin
        sioc_d    = 1'b1;
        siod_o_d  = 1'b1;
        siod_oe_d = 1'b1;
        case (state_d)
            S_START: begin
                siod_o_d = ~qtr_d[1];
            end
            S_TX: begin
                sioc_d = qtr_d[1];
                if (bit_d == 4'd8) begin
                    siod_oe_d = 1'b0;
                end else begin
                    siod_o_d = frame_d[FW-1];
                end
            end
            S_RX: begin
                sioc_d = qtr_d[1];
                if (bit_d != 4'd8) begin
                    siod_oe_d = 1'b0;
                end
            end
            S_STOP: begin
                sioc_d   = (qtr_d != 2'd0);
                siod_o_d = qtr_d[1];
            end
            default: begin
                sioc_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            qtr_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            frame_q   <= '0;
            id_q      <= '0;
            rd_q      <= 1'b0;
            phase_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            sioc_q    <= 1'b1;
            siod_o_q  <= 1'b1;
            siod_oe_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            frame_q   <= frame_d;
            id_q      <= id_d;
            rd_q      <= rd_d;
            phase_q   <= phase_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            sioc_q    <= sioc_d;
            siod_o_q  <= siod_o_d;
            siod_oe_q <= siod_oe_d;
        end
    end

    assign ready   = (state_q == S_IDLE);
    assign busy    = ~ready;
    assign done    = done_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign sioc    = sioc_q;
    assign siod_o  = siod_o_q;
    assign siod_oe = siod_oe_q;

endmodule

// File: tb/tb_sccb_master.sv
// tb/tb_sccb_master.sv - directed bench for sccb_master with a bus decoder and read slave.
module tb_sccb_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req1 = 1'b0, req2 = 1'b0;
    logic        rd_s = 1'b0;
    logic [7:0]  id_s = 8'h00, wdata_s = 8'h00;
    logic [7:0]  regi1 = 8'h00;
    logic [15:0] regi2 = 16'h0000;
    logic        ready1, done1, err1, busy1, sioc1, siod_o1, siod_oe1, siod_i1;
    logic        ready2, done2, err2, busy2, sioc2, siod_o2, siod_oe2;
    logic [7:0]  rdata1, rdata2;

    int n_total = 0, n_pass = 0, n_fail = 0;

    always #5 clk = ~clk;

    sccb_master #(.CLK_DIV(4), .REG_BYTES(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .ready(ready1), .rd(rd_s), .id(id_s),
        .regi(regi1), .wdata(wdata_s), .done(done1), .rdata(rdata1), .err(err1),
        .busy(busy1), .sioc(sioc1), .siod_o(siod_o1), .siod_oe(siod_oe1), .siod_i(siod_i1)
    );

    sccb_master #(.CLK_DIV(4), .REG_BYTES(2)) dut2 (
        .clk(clk), .rst(rst), .req(req2), .ready(ready2), .rd(rd_s), .id(id_s),
        .regi(regi2), .wdata(wdata_s), .done(done2), .rdata(rdata2), .err(err2),
        .busy(busy2), .sioc(sioc2), .siod_o(siod_o2), .siod_oe(siod_oe2), .siod_i(1'b1)
    );

    // Bus decoder: one record per completed bit cell, plus START/STOP counts.
    logic msel = 1'b0;
    logic m_sioc, m_o, m_oe, m_i;
    int   rises = 0, falls = 0, starts = 0, stops = 0;
    bit   rec_val[$];
    bit   rec_oe[$];
    logic p_sioc = 1'b1, p_o = 1'b1, p_oe = 1'b1;
    bit   pend = 1'b0, pend_val = 1'b0, pend_oe = 1'b0;
    logic [7:0] slave_byte = 8'h76;

    assign m_sioc  = msel ? sioc2 : sioc1;
    assign m_o     = msel ? siod_o2 : siod_o1;
    assign m_oe    = msel ? siod_oe2 : siod_oe1;
    assign m_i     = msel ? 1'b1 : siod_i1;
    assign siod_i1 = (falls >= 10 && falls <= 17) ? slave_byte[3'(17 - falls)] : 1'b1;

    always @(negedge clk) begin
        logic pad;
        pad = m_oe ? m_o : m_i;
        if (!rst) begin
            if (m_sioc && !p_sioc) begin
                rises++;
                pend     = 1'b1;
                pend_val = pad;
                pend_oe  = m_oe;
            end
            if (!m_sioc && p_sioc) begin
                falls++;
                if (pend) begin
                    rec_val.push_back(pend_val);
                    rec_oe.push_back(pend_oe);
                end
                pend = 1'b0;
            end
            if (m_sioc && p_sioc && m_oe && p_oe) begin
                if (!m_o && p_o) begin
                    starts++;
                    pend  = 1'b0;
                    falls = 0;
                end
                if (m_o && !p_o) begin
                    stops++;
                    pend = 1'b0;
                end
            end
        end
        p_sioc = m_sioc;
        p_o    = m_o;
        p_oe   = m_oe;
    end

    function automatic logic rec_o(input int idx);
        if (idx < 0 || idx >= rec_val.size()) return 1'bx;
        return rec_val[idx];
    endfunction

    function automatic logic rec_e(input int idx);
        if (idx < 0 || idx >= rec_oe.size()) return 1'bx;
        return rec_oe[idx];
    endfunction

    function automatic logic [7:0] get_byte(input int idx);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b = {b[6:0], rec_o(idx + i)};
        return b;
    endfunction

    function automatic logic [7:0] oe_bits(input int idx);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b = {b[6:0], rec_e(idx + i)};
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input bit sel, input bit r, input logic [7:0] i,
                         input logic [15:0] a, input logic [7:0] w);
        @(negedge clk);
        rd_s = r; id_s = i; regi1 = a[7:0]; regi2 = a; wdata_s = w;
        if (sel) req2 = 1'b1;
        else req1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req1 = 1'b0;
        req2 = 1'b0;
    endtask

    task automatic wait_done(input bit sel, output int lat);
        lat = -1;
        for (int k = 1; k <= 3000; k++) begin
            @(posedge clk);
            @(negedge clk);
            if ((sel ? done2 : done1) === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, base, s0, p0, r0, nd, extra, cyc;
        int dt[3];

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_flags", {25'd0, ready1, busy1, done1, err1, sioc1, siod_o1, siod_oe1}, 32'b1000111);
        chk("reset_rdata", {24'd0, rdata1}, 32'h00);

        // Write, REG_BYTES=1
        msel = 1'b0; base = rec_val.size(); s0 = starts; p0 = stops;
        issue(1'b0, 1'b0, 8'h42, 16'h0012, 8'h80);
        chk("wr_busy", {30'd0, ready1, busy1}, 32'b01);
        wait_done(1'b0, lat);
        chk("wr_latency", 32'(lat), 32'd480);
        chk("wr_ready_err", {30'd0, ready1, err1}, 32'b10);
        chk("wr_rdata_kept", {24'd0, rdata1}, 32'h00);
        chk("wr_nbits", 32'(rec_val.size() - base), 32'd27);
        chk("wr_start_stop", {16'(starts - s0), 16'(stops - p0)}, {16'd1, 16'd1});
        chk("wr_bytes", {8'd0, get_byte(base), get_byte(base + 9), get_byte(base + 18)}, 32'h00421280);
        chk("wr_data_oe", {8'd0, oe_bits(base), oe_bits(base + 9), oe_bits(base + 18)}, 32'h00FFFFFF);
        chk("wr_ack_oe", {29'd0, rec_e(base + 8), rec_e(base + 17), rec_e(base + 26)}, 32'b000);
        @(negedge clk);
        chk("wr_done_pulse", {31'd0, done1}, 32'd0);

        // Write, REG_BYTES=2
        msel = 1'b1;
        @(negedge clk);
        base = rec_val.size();
        issue(1'b1, 1'b0, 8'h42, 16'h3A5C, 8'h01);
        wait_done(1'b1, lat);
        chk("rb2_latency", 32'(lat), 32'd624);
        chk("rb2_nbits", 32'(rec_val.size() - base), 32'd36);
        chk("rb2_bytes", {get_byte(base), get_byte(base + 9), get_byte(base + 18), get_byte(base + 27)}, 32'h423A5C01);
        chk("rb2_err", {31'd0, err2}, 32'd0);
        msel = 1'b0;
        @(negedge clk);

        // Back-to-back with req held high
        @(negedge clk);
        rd_s = 1'b0; id_s = 8'h42; regi1 = 8'h12; wdata_s = 8'h80;
        req1 = 1'b1;
        nd = 0; cyc = 0;
        for (int c = 0; c < 2000 && nd < 3; c++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done1 === 1'b1) begin
                dt[nd] = cyc;
                nd++;
                if (nd == 3) req1 = 1'b0;
            end
        end
        req1 = 1'b0;
        chk("b2b_count", 32'(nd), 32'd3);
        chk("b2b_first", 32'(dt[0]), 32'd481);
        chk("b2b_gap1", 32'(dt[1] - dt[0]), 32'd481);
        chk("b2b_gap2", 32'(dt[2] - dt[1]), 32'd481);
        extra = 0;
        repeat (600) begin
            @(posedge clk);
            @(negedge clk);
            if (done1 === 1'b1) extra++;
        end
        chk("b2b_no_extra", {extra[30:0], ready1}, 32'd1);

        // Reset during the second byte
        issue(1'b0, 1'b0, 8'h42, 16'h0012, 8'h80);
        repeat (193) @(negedge clk);
        chk("rst_pre", {28'd0, sioc1, siod_o1, siod_oe1, ready1}, 32'b0010);
        rst = 1'b1;
        #1;
        chk("rst_async", {27'd0, sioc1, siod_o1, siod_oe1, ready1, done1}, 32'b11110);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (done1 === 1'b1) extra++;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done1 === 1'b1) extra++;
        end
        chk("rst_no_done", 32'(extra), 32'd0);
        base = rec_val.size();
        issue(1'b0, 1'b0, 8'h43, 16'h0012, 8'h80);
        wait_done(1'b0, lat);
        chk("rst_next_latency", 32'(lat), 32'd480);
        chk("rst_next_bytes", {8'd0, get_byte(base), get_byte(base + 9), get_byte(base + 18)}, 32'h00421280);
        @(negedge clk);

`ifdef SCCB_READ_EN
        base = rec_val.size(); s0 = starts; p0 = stops;
        issue(1'b0, 1'b1, 8'h43, 16'h000A, 8'h00);
        wait_done(1'b0, lat);
        chk("rd_latency", 32'(lat), 32'd672);
        chk("rd_rdata_err", {23'd0, rdata1, err1}, {23'd0, 8'h76, 1'b0});
        chk("rd_nbits", 32'(rec_val.size() - base), 32'd36);
        chk("rd_start_stop", {16'(starts - s0), 16'(stops - p0)}, {16'd2, 16'd2});
        chk("rd_bytes", {get_byte(base), get_byte(base + 9), get_byte(base + 18), get_byte(base + 27)}, 32'h420A4376);
        chk("rd_rx_oe", {24'd0, oe_bits(base + 27)}, 32'h00);
        chk("rd_na", {30'd0, rec_o(base + 35), rec_e(base + 35)}, 32'b11);
`else
        r0 = rises;
        issue(1'b0, 1'b1, 8'h43, 16'h000A, 8'h00);
        wait_done(1'b0, lat);
        chk("rdoff_latency", 32'(lat), 32'd2);
        chk("rdoff_err_rdata", {23'd0, err1, rdata1}, {23'd0, 1'b1, 8'h00});
        chk("rdoff_no_sioc", 32'(rises - r0), 32'd0);
        chk("rdoff_bus_idle", {29'd0, sioc1, siod_o1, siod_oe1}, 32'b111);
`endif
        @(negedge clk);
        chk("final_idle", {30'd0, ready1, done1}, 32'b10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
